kernel_cnn_mul_pipe: RTL and testbench

KERNEL_CNN_MUL_PIPE -- requirements
Module: kernel_cnn_mul_pipe

---
 rtl/kernel_cnn_pkg.sv | 24 ++
 rtl/kernel_cnn_mul_core.sv | 36 +++
 rtl/kernel_cnn_mul_pipe.sv | 105 ++++++++++
 tb/tb_kernel_cnn_mul_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_cnn_pkg.sv
// Shared defaults and the per-stage pipeline record for the CNN multiply pipe.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// stage_t travels down the pipeline. Its data field is sized for the widest
// result the pipe supports; each instance uses only the low DOUT_W bits, and
// the constant-zero upper bits are trimmed by synthesis.
package kernel_cnn_pkg;

    localparam int DIN0_W_DEF    = 8;
    localparam int DIN1_W_DEF    = 16;
    localparam int DOUT_W_DEF    = 23;
    localparam int NUM_STAGE_DEF = 3;
    localparam int NUM_STAGE_MAX = 8;
    localparam int STAGE_DATA_W  = 64;

    typedef struct packed {
        logic                    vld;   // stage holds a real beat
        logic                    sgn;   // operands were two's complement
        logic                    acc;   // beat adds onto the previous result
        logic [STAGE_DATA_W-1:0] data;  // product, or final result in the last stage
    } stage_t;

endpackage

// File: rtl/kernel_cnn_mul_core.sv
// Combinational signed/unsigned multiplier, (A_W+1) x (B_W+1) operands.
// Latency: 0 cycles; the enclosing pipeline supplies the registers.
// Backpressure: none, pure logic.
//
// Ports: a, b operands; sgn selects two's complement (1) or unsigned (0)
// extension; p is the low P_W bits of the exact product.
module kernel_cnn_mul_core #(
    parameter int A_W = 8,
    parameter int B_W = 16,
    parameter int P_W = 23
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic           sgn,
    output logic [P_W-1:0] p
);

    // One extra bit per operand lets a single signed multiplier cover both
    // modes: the extra bit is the sign bit when sgn=1 and zero otherwise.
    logic [A_W:0] a_e;
    logic [B_W:0] b_e;

    assign a_e = {sgn & a[A_W-1], a};
    assign b_e = {sgn & b[B_W-1], b};

    // Only the low P_W result bits are ever used, and those depend only on
    // the low P_W bits of each sign-extended operand, so the multiply is
    // done at P_W bits instead of building the full-width product.
    logic [P_W-1:0] a_w;
    logic [P_W-1:0] b_w;

    assign a_w = P_W'($signed(a_e));
    assign b_w = P_W'($signed(b_e));
    assign p   = a_w * b_w;

endmodule

// File: rtl/kernel_cnn_mul_pipe.sv
// Pipelined multiply / multiply-accumulate with valid-ready handshake on both sides.
// Latency: NUM_STAGE cycles from input acceptance to out_valid, plus one per stall cycle.
// Backpressure: in_ready = !(out_valid && !out_ready); the whole pipe and accumulator freeze while stalled.
//
// Ports: ap_clk / ap_rst_n (async, active-low); input beat in_valid/in_ready with
// din0, din1, in_signed, in_acc; output beat out_valid/out_ready with dout.
module kernel_cnn_mul_pipe
    import kernel_cnn_pkg::*;
#(
    parameter int DIN0_W    = DIN0_W_DEF,
    parameter int DIN1_W    = DIN1_W_DEF,
    parameter int DOUT_W    = DOUT_W_DEF,
    parameter int NUM_STAGE = NUM_STAGE_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN0_W-1:0] din0,
    input  logic [DIN1_W-1:0] din1,
    input  logic              in_signed,
    input  logic              in_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] dout
);

    localparam int LAST = NUM_STAGE - 1;

    stage_t            s_q [NUM_STAGE];
    logic [DOUT_W-1:0] acc_q;
    logic [DOUT_W-1:0] prod;
    logic [DOUT_W-1:0] src_data;
    logic [DOUT_W-1:0] fin_data;
    stage_t            in_rec;
    stage_t            src;
    stage_t            fin;
    logic              stall;

    // The multiplier is purely combinational; its result is captured by the
    // first pipeline register so the remaining stages act as retiming slack.
    kernel_cnn_mul_core #(
        .A_W (DIN0_W),
        .B_W (DIN1_W),
        .P_W (DOUT_W)
    ) u_mul (
        .a   (din0),
        .b   (din1),
        .sgn (in_signed),
        .p   (prod)
    );

    assign stall     = s_q[LAST].vld & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = s_q[LAST].vld;
    assign dout      = s_q[LAST].data[DOUT_W-1:0];

    always_comb begin
        in_rec      = '0;
        in_rec.vld  = in_valid;
        in_rec.sgn  = in_signed;
        in_rec.acc  = in_acc;
        in_rec.data = STAGE_DATA_W'(prod);
    end

    // Beat that loads the final stage on the next advance: the input itself
    // for a single-stage pipe, otherwise the second-to-last stage.
    if (NUM_STAGE == 1) begin : g_src_in
        assign src = in_rec;
    end else begin : g_src_pipe
        assign src = s_q[NUM_STAGE-2];
    end

    // acc_q always mirrors the newest beat in the final stage, consumed or not,
    // so an accumulating beat chains onto its immediate predecessor.
    assign src_data = src.data[DOUT_W-1:0];
    assign fin_data = src.acc ? (acc_q + src_data) : src_data;

    always_comb begin
        fin      = src;
        fin.data = STAGE_DATA_W'(fin_data);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                s_q[i] <= '0;
            end
            acc_q <= '0;
        end else if (!stall) begin
            if (NUM_STAGE > 1) begin
                s_q[0] <= in_rec;
            end
            for (int i = 1; i < LAST; i++) begin
                s_q[i] <= s_q[i-1];
            end
            s_q[LAST] <= fin;
            // Bubbles pass through without disturbing the running sum.
            if (src.vld) begin
                acc_q <= fin_data;
            end
        end
    end

endmodule

// File: tb/tb_kernel_cnn_mul_pipe.sv
// Scoreboard bench: three DUT copies (default, NUM_STAGE=1/DOUT_W=24,
// NUM_STAGE=8/DOUT_W=24) each with its own driver and negedge monitor.
module tb_kernel_cnn_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] exp;
        int          acc_cyc;
        bit          chk_lat;
    } sb_t;

    function automatic logic [63:0] mask_w(input int dw);
        return (dw >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw) - 64'd1);
    endfunction

    // Exact integer product of the operands read as signed or unsigned
    // numbers, reduced modulo 2^dw.
    function automatic logic [63:0] ref_prod(input logic [7:0] a, input logic [15:0] b,
                                             input logic s, input int dw);
        longint pa;
        longint pb;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        return 64'(pa * pb) & mask_w(dw);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NS = (g == 0) ? 3 : ((g == 1) ? 1 : 8);
        localparam int DW = (g == 0) ? 23 : 24;

        logic          rst_n     = 1'b0;
        logic          in_valid  = 1'b0;
        logic          in_ready;
        logic [7:0]    din0      = '0;
        logic [15:0]   din1      = '0;
        logic          in_signed = 1'b0;
        logic          in_acc    = 1'b0;
        logic          out_valid;
        logic          out_ready = 1'b0;
        logic [DW-1:0] dout_n;
        logic [63:0]   dout;
        logic          gold_vld  = 1'b0;
        logic [63:0]   gold      = '0;
        int            rdy_mode  = 1;    // 0 random, 1 always ready, 2 scripted
        bit            done      = 1'b0;
        bit            tmo       = 1'b0;

        sb_t         q[$];
        logic [63:0] accm       = '0;
        bit          prev_hold  = 1'b0;
        bit          prev_rst_n = 1'b0;
        logic [63:0] prev_dout  = '0;
        logic [63:0] p_m;
        logic [63:0] e_m;

        assign dout = 64'(dout_n);

        kernel_cnn_mul_pipe #(
            .DIN0_W    (8),
            .DIN1_W    (16),
            .DOUT_W    (DW),
            .NUM_STAGE (NS)
        ) u_dut (
            .ap_clk    (clk),
            .ap_rst_n  (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .din0      (din0),
            .din1      (din1),
            .in_signed (in_signed),
            .in_acc    (in_acc),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .dout      (dout_n)
        );

        // Monitor: records accepted beats against the reference model and
        // checks every presented / consumed result plus the handshake rules.
        always @(negedge clk) begin
            if (!rst_n) begin
                checks = checks + 2;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL inst%0d reset_out_valid got %b want 0", g, out_valid);
                end
                if (dout !== 64'd0) begin
                    errors++;
                    $display("FAIL inst%0d reset_dout got %h want 0", g, dout);
                end
                q.delete();
                accm       = '0;
                prev_hold  = 1'b0;
                prev_rst_n = 1'b0;
            end else begin
                if (!prev_rst_n) begin
                    checks++;
                    if (in_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL inst%0d ready_after_reset got %b want 1", g, in_ready);
                    end
                end
                checks++;
                if (in_ready !== !(out_valid && !out_ready)) begin
                    errors++;
                    $display("FAIL inst%0d ready_rule got %b want %b", g, in_ready, !(out_valid && !out_ready));
                end
                if (prev_hold) begin
                    checks++;
                    if (out_valid !== 1'b1 || dout !== prev_dout) begin
                        errors++;
                        $display("FAIL inst%0d hold got v=%b d=%h want v=1 d=%h", g, out_valid, dout, prev_dout);
                    end
                end
                if (out_valid === 1'b1) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL inst%0d spurious_output got d=%h want no output", g, dout);
                    end else begin
                        if (!prev_hold && q[0].chk_lat) begin
                            checks++;
                            if (cyc - q[0].acc_cyc + 1 != NS) begin
                                errors++;
                                $display("FAIL inst%0d latency got %0d want %0d", g, cyc - q[0].acc_cyc + 1, NS);
                            end
                        end
                        if (out_ready) begin
                            checks++;
                            if (dout !== q[0].exp) begin
                                errors++;
                                $display("FAIL inst%0d data got %h want %h", g, dout, q[0].exp);
                            end
                            void'(q.pop_front());
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    p_m  = ref_prod(din0, din1, in_signed, DW);
                    e_m  = in_acc ? ((accm + p_m) & mask_w(DW)) : p_m;
                    accm = e_m;
                    q.push_back('{gold_vld ? gold : e_m, cyc + 1, rdy_mode == 1});
                end
                prev_hold  = out_valid && !out_ready;
                prev_dout  = dout;
                prev_rst_n = 1'b1;
            end
            if (tmo) begin
                checks++;
                errors++;
                $display("FAIL inst%0d handshake_timeout got stuck want progress", g);
                tmo = 1'b0;
            end
        end

        initial begin : rdy_gen
            forever begin
                @(posedge clk);
                #1;
                if (rdy_mode == 0)      out_ready = ($urandom_range(0, 3) != 0);
                else if (rdy_mode == 1) out_ready = 1'b1;
            end
        end

        task automatic send(input logic [7:0] a, input logic [15:0] b, input logic s,
                            input logic ac, input logic gv, input logic [63:0] gd);
            bit ok;
            ok        = 1'b0;
            in_valid  = 1'b1;
            din0      = a;
            din1      = b;
            in_signed = s;
            in_acc    = ac;
            gold_vld  = gv;
            gold      = gd;
            for (int k = 0; k < 2000; k++) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                if (ok) break;
            end
            if (!ok) tmo = 1'b1;
            in_valid = 1'b0;
            gold_vld = 1'b0;
        endtask

        task automatic rnd_send();
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, 64'd0);
        endtask

        task automatic drain();
            for (int k = 0; k < 5000 && q.size() != 0; k++) @(posedge clk);
            if (q.size() != 0) tmo = 1'b1;
            @(posedge clk);
            #1;
        endtask

        initial begin : drv
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            if (g == 0) begin
                // Hand-computed results at the default widths.
                send(8'hFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 64'h7EFF01);
                send(8'hFF, 16'h0002, 1'b1, 1'b0, 1'b1, 64'h7FFFFE);
                send(8'd3,  16'd4,    1'b0, 1'b0, 1'b1, 64'd12);
                send(8'd5,  16'd6,    1'b0, 1'b1, 1'b1, 64'd42);
                send(8'd1,  16'd1,    1'b0, 1'b1, 1'b1, 64'd43);
                drain();
                // Ten-beat stream with the consumer stalled in cycles 4..7.
                rdy_mode = 2;
                fork
                    begin
                        for (int c = 0; c < 14; c++) begin
                            out_ready = !(c >= 4 && c <= 7);
                            @(posedge clk);
                            #1;
                        end
                        out_ready = 1'b1;
                    end
                    begin
                        for (int i = 0; i < 10; i++)
                            send(8'(i + 1), 16'(100 + i), 1'b0, 1'b0, 1'b1, 64'((i + 1) * (100 + i)));
                    end
                join
                drain();
                rdy_mode = 1;
                @(posedge clk);
                #1;
                // Reset with two beats in flight; the next accumulate starts from zero.
                send(8'd2, 16'd3, 1'b0, 1'b0, 1'b0, 64'd0);
                send(8'd4, 16'd5, 1'b0, 1'b0, 1'b0, 64'd0);
                rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                send(8'd7, 16'd9, 1'b0, 1'b1, 1'b1, 64'd63);
                drain();
                rdy_mode = 0;
                for (int i = 0; i < 3000; i++) rnd_send();
                drain();
            end else begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 500; i++) rnd_send();
                drain();
                rdy_mode = 0;
                for (int i = 0; i < 9500; i++) rnd_send();
                drain();
            end
            done = 1'b1;
        end
    end

    initial begin : top_ctl
        for (int c = 0; c < 90000; c++) begin
            if (g_dut[0].done && g_dut[1].done && g_dut[2].done) break;
            @(posedge clk);
        end
        if (!(g_dut[0].done && g_dut[1].done && g_dut[2].done)) begin
            $display("FAIL run_timeout got done=%b%b%b want 111",
                     g_dut[0].done, g_dut[1].done, g_dut[2].done);
            $fatal(1, "bench stopped: drivers did not complete");
        end
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
